mw_add_sequencer: RTL
=====================

Name: mw_add_sequencer

Overview:
Multi-word add/subtract controller. It sequences one 32-bit full-adder datapath (A + B + Cin, 33-bit result) over WORDS consecutive operand words, LS word first, and chains the carry between words. Operands stream in and results stream out over valid/ready handshakes. The block lets narrow adder hardware serve wide (e.g. 128-bit) arithmetic requests from the ALU/datapath layer.

Parameters:
WIDTH, 32, bits per operand word (adder width)
WORDS, 4, words per operation (operation width = WIDTH*WORDS); legal range 1..256

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  begin operation; sampled only in IDLE
sub  input  1  operation select, sampled with start: 0 = A+B, 1 = A-B
abort  input  1  synchronous cancel of the current operation
in_valid  input  1  operand word pair valid
in_ready  output  1  block accepts operand word this cycle
in_a  input  WIDTH  operand A word
in_b  input  WIDTH  operand B word
out_valid  output  1  result word valid
out_ready  input  1  consumer accepts result word
out_sum  output  WIDTH  result word
out_last  output  1  qualifies final result word (with out_valid)
carry_out  output  1  final carry (sub: 1 = no borrow); valid from final word until next start
overflow  output  1  signed overflow of the full-width result; same validity as carry_out
busy  output  1  high in any state except IDLE
done  output  1  one-cycle pulse on completion

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE. in_ready, out_valid, out_last, busy, done, carry_out and overflow are 0. out_sum = 0. Word counter = 0. Carry register = 0.
- States: IDLE, RUN, FLUSH, DONE.
- IDLE: on start=1, latch sub, set carry register = sub, set counter = 0, and go to RUN. Assertion of start outside IDLE is ignored, with no side effects.
- RUN: in_ready = !out_valid || out_ready, so the block holds a single output register and runs at one word per cycle when out_ready is held high.
- Accept occurs when in_valid && in_ready. On accept:
  - b_eff = sub ? ~in_b : in_b.
  - {c, s} = in_a + b_eff + carry register, computed at WIDTH+1 bits.
  - Register out_sum = s and assert out_valid. The carry register takes c.
  - Increment the counter.
- Latency: a result word appears one cycle after its operand accept.
- Final word (counter == WORDS-1): on accept, set out_last=1 with that word, and latch carry_out = c and overflow = (in_a[MSB] == b_eff[MSB]) && (s[MSB] != in_a[MSB]). Then go to FLUSH. in_ready drops the next cycle.
- out_valid/out_sum/out_last stay stable until out_valid && out_ready. Consumer stall never drops or duplicates a word.
- FLUSH: wait for the handshake of the last word, then clear out_valid/out_last and go to DONE.
- DONE: done=1 for one cycle, busy=1, then IDLE. carry_out and overflow hold until the next accepted start, where they are cleared.
- WORDS=1: the first accept is also the final accept.
- abort=1 in RUN/FLUSH/DONE: next cycle is IDLE. Clear out_valid, out_last and in_ready. carry_out and overflow become 0. done is not pulsed. abort in IDLE has no effect. abort has priority over start and accept in the same cycle.
- Reset mid-operation behaves as abort plus full register reset.
- in_valid while not RUN is ignored, and in_ready = 0.
- Counter width is ceil(log2(WORDS+1)) and never wraps within an operation.

Test Plan:
- WORDS=4, add, A = 0xFFFFFFFF x4, B = 0x00000001,0,0,0, out_ready=1 -> out words 0x00000000 x4. out_last on the 4th word, carry_out=1, overflow=0, single done pulse, busy low the following cycle.
- WORDS=2, sub, A = {0,5}, B = {0,7} (LS first 5/7) -> 0xFFFFFFFE then 0xFFFFFFFF. carry_out=0 (borrow), overflow=0.
- WORDS=2, add, A = {0x7FFFFFFF,0xFFFFFFFF}, B = {0,1} -> 0x00000000 then 0x80000000. carry_out=0, overflow=1.
- Backpressure: out_ready low for 3 cycles after the first result -> in_ready=0 during the stall. out_sum is stable. No word is lost or repeated, and the final result matches the unstalled run.
- start pulsed during RUN, and in_valid asserted in IDLE -> no state change and no accept. Operation result is unaffected.
- abort asserted after word 2 of 4, then rst_n=0 mid-operation in a second run -> IDLE next cycle, outputs at reset values, no done pulse. A following fresh start completes correctly.

Source files
------------

// File: rtl/mw_add_sequencer.sv
// Multi-word add/subtract sequencer: chains one WIDTH-bit adder over WORDS
// operand words (LS word first) with valid/ready streaming on both sides.
//
// state | meaning
// IDLE  | waiting for start; in_ready low
// RUN   | accepting operand words, one result register in flight
// FLUSH | final word registered, waiting for its handshake
// DONE  | one-cycle completion pulse, then back to IDLE
module mw_add_sequencer #(
  parameter int WIDTH = 32,
  parameter int WORDS = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic             abort_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_a_i,
  input  logic [WIDTH-1:0] in_b_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_sum_o,
  output logic             out_last_o,
  output logic             carry_out_o,
  output logic             overflow_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int CW = $clog2(WORDS + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             sub_q, sub_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [WIDTH-1:0] out_sum_q, out_sum_d;
  logic             carry_out_q, carry_out_d;
  logic             overflow_q, overflow_d;

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   add_res;
  logic             accept;
  logic             out_fire;
  logic             final_word;
  logic             ovf_word;

  assign b_eff      = sub_q ? ~in_b_i : in_b_i;
  assign add_res    = {1'b0, in_a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, carry_q};
  assign final_word = (cnt_q == CW'(WORDS - 1));
  assign ovf_word   = (in_a_i[WIDTH-1] == b_eff[WIDTH-1]) &&
                      (add_res[WIDTH-1] != in_a_i[WIDTH-1]);
  assign out_fire   = out_valid_q && out_ready_i;

  // abort wins over accept, so keep in_ready low while it is asserted
  assign in_ready_o = (state_q == S_RUN) && !abort_i && (!out_valid_q || out_ready_i);
  assign accept     = in_valid_i && in_ready_o;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    sub_d       = sub_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_sum_d   = out_sum_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    done_o      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          sub_d       = sub_i;
          carry_d     = sub_i;
          cnt_d       = '0;
          carry_out_d = 1'b0;
          overflow_d  = 1'b0;
          state_d     = S_RUN;
        end
      end
      S_RUN: begin
        if (accept) begin
          out_sum_d   = add_res[WIDTH-1:0];
          out_valid_d = 1'b1;
          carry_d     = add_res[WIDTH];
          cnt_d       = cnt_q + CW'(1);
          if (final_word) begin
            out_last_d  = 1'b1;
            carry_out_d = add_res[WIDTH];
            overflow_d  = ovf_word;
            state_d     = S_FLUSH;
          end
        end else if (out_fire) begin
          out_valid_d = 1'b0;
        end
      end
      S_FLUSH: begin
        if (out_fire) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort_i && (state_q != S_IDLE)) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      carry_out_d = 1'b0;
      overflow_d  = 1'b0;
      done_o      = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      sub_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_sum_q   <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      sub_q       <= sub_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_sum_q   <= out_sum_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_last_o  = out_last_q;
  assign out_sum_o   = out_sum_q;
  assign carry_out_o = carry_out_q;
  assign overflow_o  = overflow_q;
  assign busy_o      = (state_q != S_IDLE);

endmodule
